// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and types for the register-bank write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 32;

    // Requester IDs, used as bit positions in req/gnt vectors.
    localparam int unsigned REQ_WB = 0;
    localparam int unsigned REQ_LD = 1;

    // Which requester wins the next two-way contention.
    typedef enum logic {
        PTR_WB = 1'b0,
        PTR_LD = 1'b1
    } ptr_e;

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// Two-request arbiter: round-robin, or fixed priority with wb always winning.
module rr_arbiter2
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned USE_RR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    ptr_e ptr_q;
    ptr_e ptr_d;

    // Grant: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            if ((USE_RR != 0) && (ptr_q == PTR_LD)) begin
                gnt[REQ_LD] = 1'b1;
            end else begin
                gnt[REQ_WB] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    // Pointer moves to the other requester after every grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ_WB]) begin
            ptr_d = PTR_LD;
        end else if (gnt[REQ_LD]) begin
            ptr_d = PTR_WB;
        end
    end

    // Pointer register, resets to favour wb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_WB;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the bank write port between wb and ld, and tracks pending destinations.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned AW     = reg_write_arbiter_pkg::AW,
    parameter int unsigned DW     = reg_write_arbiter_pkg::DW,
    parameter int unsigned NREGS  = reg_write_arbiter_pkg::NREGS,
    parameter int unsigned USE_RR = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_reg,
    input  logic [DW-1:0]    wb_data,
    output logic             wb_ready,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_reg,
    input  logic [DW-1:0]    ld_data,
    output logic             ld_ready,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_reg,
    input  logic [AW-1:0]    chk_reg1,
    input  logic [AW-1:0]    chk_reg2,
    output logic             stall,
    output logic             escreve,
    output logic [AW-1:0]    regF,
    output logic [DW-1:0]    dados,
    output logic [NREGS-1:0] pending,
    output logic             rsv_err
);

    logic [1:0]       gnt;
    logic             escreve_q, escreve_d;
    logic [AW-1:0]    regf_q, regf_d;
    logic [DW-1:0]    dados_q, dados_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             rsv_err_q, rsv_err_d;

    rr_arbiter2 #(
        .USE_RR (USE_RR)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({ld_valid, wb_valid}),
        .gnt   (gnt)
    );

    assign wb_ready = gnt[REQ_WB];
    assign ld_ready = gnt[REQ_LD];

    // Output stage: capture the granted write; address/data hold when idle.
    always_comb begin
        escreve_d = |gnt;
        regf_d    = regf_q;
        dados_d   = dados_q;
        if (gnt[REQ_WB]) begin
            regf_d  = wb_reg;
            dados_d = wb_data;
        end else if (gnt[REQ_LD]) begin
            regf_d  = ld_reg;
            dados_d = ld_data;
        end
    end

    // Scoreboard: clear on the bank write edge, then set so a new reservation wins.
    always_comb begin
        pending_d = pending_q;
        rsv_err_d = rsv_err_q;
        if (escreve_q) begin
            pending_d[regf_q] = 1'b0;
        end
        if (rsv_valid) begin
            if (pending_d[rsv_reg]) begin
                rsv_err_d = 1'b1;
            end
            pending_d[rsv_reg] = 1'b1;
        end
    end

    // State registers for output stage and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            escreve_q <= 1'b0;
            regf_q    <= '0;
            dados_q   <= '0;
            pending_q <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            escreve_q <= escreve_d;
            regf_q    <= regf_d;
            dados_q   <= dados_d;
            pending_q <= pending_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    assign stall   = pending_q[chk_reg1] | pending_q[chk_reg2];
    assign escreve = escreve_q;
    assign regF    = regf_q;
    assign dados   = dados_q;
    assign pending = pending_q;
    assign rsv_err = rsv_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench: round-robin and fixed-priority instances share stimulus; each is
// compared against a behavioural model of the arbiter rules.
module tb_reg_write_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0, ld_valid = 1'b0, rsv_valid = 1'b0;
    logic [AW-1:0] wb_reg = '0, ld_reg = '0, rsv_reg = '0, chk_reg1 = '0, chk_reg2 = '0;
    logic [DW-1:0] wb_data = '0, ld_data = '0;

    logic          wb_ready [2];
    logic          ld_ready [2];
    logic          stall    [2];
    logic          escreve  [2];
    logic [AW-1:0] regF     [2];
    logic [DW-1:0] dados    [2];
    logic [NR-1:0] pending  [2];
    logic          rsv_err  [2];

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.USE_RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready[0]),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready[0]),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .stall(stall[0]), .escreve(escreve[0]), .regF(regF[0]), .dados(dados[0]),
        .pending(pending[0]), .rsv_err(rsv_err[0])
    );

    reg_write_arbiter #(.USE_RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready[1]),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready[1]),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .stall(stall[1]), .escreve(escreve[1]), .regF(regF[1]), .dados(dados[1]),
        .pending(pending[1]), .rsv_err(rsv_err[1])
    );

    // Reference model state per instance (0 = round-robin, 1 = fixed priority).
    int            m_last [2];   // last granted requester: 0 wb, 1 ld
    bit            m_esc  [2];
    int            m_reg  [2];
    logic [DW-1:0] m_dat  [2];
    bit            m_pend [2][NR];
    bit            m_err  [2];
    int            m_win  [2];   // -1 none, 0 wb, 1 ld

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            m_esc[k]  = 0;
            m_reg[k]  = 0;
            m_dat[k]  = '0;
            m_err[k]  = 0;
            for (int r = 0; r < NR; r++) m_pend[k][r] = 0;
        end
    endtask

    function automatic logic [NR-1:0] pend_vec(input int k);
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++) v[r] = m_pend[k][r];
        return v;
    endfunction

    // Who wins this cycle under the arbitration rules.
    task automatic m_decide();
        for (int k = 0; k < 2; k++) begin
            if (wb_valid && ld_valid) m_win[k] = (k == 1) ? 0 : 1 - m_last[k];
            else if (wb_valid)        m_win[k] = 0;
            else if (ld_valid)        m_win[k] = 1;
            else                      m_win[k] = -1;
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            check("escreve", k, 64'(escreve[k]), 64'(m_esc[k]));
            check("regF",    k, 64'(regF[k]),    64'(m_reg[k]));
            check("dados",   k, 64'(dados[k]),   64'(m_dat[k]));
            check("pending", k, 64'(pending[k]), 64'(pend_vec(k)));
            check("rsv_err", k, 64'(rsv_err[k]), 64'(m_err[k]));
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        #1;
        m_decide();
        for (int k = 0; k < 2; k++) begin
            check("wb_ready", k, 64'(wb_ready[k]), 64'(m_win[k] == 0));
            check("ld_ready", k, 64'(ld_ready[k]), 64'(m_win[k] == 1));
            check("stall",    k, 64'(stall[k]),
                  64'(m_pend[k][int'(chk_reg1)] || m_pend[k][int'(chk_reg2)]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_esc[k]) m_pend[k][m_reg[k]] = 0;
            if (rsv_valid) begin
                if (m_pend[k][int'(rsv_reg)]) m_err[k] = 1;
                m_pend[k][int'(rsv_reg)] = 1;
            end
            m_esc[k] = (m_win[k] >= 0);
            if (m_win[k] == 0) begin m_reg[k] = int'(wb_reg); m_dat[k] = wb_data; end
            if (m_win[k] == 1) begin m_reg[k] = int'(ld_reg); m_dat[k] = ld_data; end
            if (m_win[k] >= 0) m_last[k] = m_win[k];
        end
        #1;
        check_regs();
    endtask

    task automatic idle();
        wb_valid = 0; ld_valid = 0; rsv_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        m_reset();
        #3;
        check_regs();
        do_reset();

        // Single writer on r5 with stall tracking.
        chk_reg1 = 5; chk_reg2 = 9;
        rsv_valid = 1; rsv_reg = 5; step();
        rsv_valid = 0;
        wb_valid = 1; wb_reg = 5; wb_data = 32'hDEAD_BEEF; step();
        idle(); step();
        check("r5_cleared", 0, 64'(pending[0][5]), 64'd0);
        step();

        // Contention: four cycles of wb r1 and ld r2.
        wb_valid = 1; wb_reg = 1; wb_data = 32'h1111_0001;
        ld_valid = 1; ld_reg = 2; ld_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) step();
        wb_valid = 0; step();
        idle(); step();

        // Set/clear collision on r7, then a genuine double reservation.
        do_reset();
        wb_valid = 1; wb_reg = 7; wb_data = 32'h0000_0077; step();
        idle(); rsv_valid = 1; rsv_reg = 7; step();
        check("r7_collision_err", 0, 64'(rsv_err[0]), 64'd0);
        check("r7_collision_pend", 0, 64'(pending[0][7]), 64'd1);
        step();
        check("r7_double_err", 0, 64'(rsv_err[0]), 64'd1);
        idle(); step(); step();

        // Stall mapping with only r3 pending.
        do_reset();
        rsv_valid = 1; rsv_reg = 3; step();
        idle(); chk_reg1 = 0; chk_reg2 = 3; step();
        chk_reg2 = 4; step();

        // Asynchronous reset mid-operation with r4 pending.
        do_reset();
        rsv_valid = 1; rsv_reg = 4; step();
        wb_valid = 1; wb_reg = 4; wb_data = 32'hCAFE_0004; ld_valid = 1; ld_reg = 6; step();
        check("pre_reset_pend", 0, 64'(pending[0]), 64'h0000_0010);
        #2;
        rst_n = 0;
        idle();
        m_reset();
        #1;
        check_regs();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Randomised traffic; wb/ld hold their request until the RR instance accepts.
        for (int i = 0; i < 400; i++) begin
            if (!wb_valid || m_win[0] == 0) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_reg   = AW'($urandom_range(0, 7));
                wb_data  = $urandom;
            end
            if (!ld_valid || m_win[0] == 1) begin
                ld_valid = ($urandom_range(0, 2) == 0);
                ld_reg   = AW'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_reg   = AW'($urandom_range(0, 7));
            chk_reg1  = AW'($urandom_range(0, 7));
            chk_reg2  = AW'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
